tas_avg_ctrl: RTL

//  Read-side (clk_2) controller for the temperature acquisition datapath.
//  - Drains header-qualified bytes from the 50->2 MHz FIFO.
//  - Averages each group of SAMPLES bytes.
//  - Writes each average to the external RAM with a down-counting address.
//  - Sequences FIFO pops, the accumulator and the RAM write strobe from one FSM.

---
 rtl/tas_avg_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/tas_avg_ctrl.sv
// Read-side controller: pops FIFO bytes, averages each SAMPLES-byte group and
// writes the average to external RAM at a down-counting, wrapping address.
module tas_avg_ctrl #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 11,
  parameter int unsigned       SAMPLES    = 4,
  parameter logic [ADDR_W-1:0] ADDR_START = {ADDR_W{1'b1}}
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_fifo,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy
);

  localparam int unsigned ShiftW = $clog2(SAMPLES);
  localparam int unsigned SumW   = DATA_W + ShiftW;
  localparam int unsigned CntW   = $clog2(SAMPLES + 1);

  typedef enum logic [2:0] {StIdle, StPop, StCapt, StWrite, StNext} state_e;

  state_e              state_q, state_d;
  logic [SumW-1:0]     sum_q, sum_d, sum_next;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rd_fifo_q, rd_fifo_d;
  logic                ram_wr_n_q, ram_wr_n_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                busy_q, busy_d;

  assign sum_next = sum_q + SumW'(fifo_data);

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StPop;
      end
      StPop: begin
        state_d = StCapt;
      end
      StCapt: begin
        sum_d = sum_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_d == CntW'(SAMPLES)) begin
          // Load the average on entry to WRITE so it is valid for the whole strobe.
          ram_data_d = DATA_W'(sum_next >> ShiftW);
          state_d    = StWrite;
        end else begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        state_d = StNext;
      end
      StNext: begin
        sum_d      = '0;
        cnt_d      = '0;
        ram_addr_d = (ram_addr_q == '0) ? ADDR_START : ram_addr_q - ADDR_W'(1);
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so decode them from the next state.
    rd_fifo_d  = (state_d == StPop);
    ram_wr_n_d = (state_d != StWrite);
    busy_d     = (cnt_d != '0) || (state_d == StWrite) || (state_d == StNext);
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      cnt_q      <= '0;
      rd_fifo_q  <= 1'b0;
      ram_wr_n_q <= 1'b1;
      ram_data_q <= '0;
      ram_addr_q <= ADDR_START;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      rd_fifo_q  <= rd_fifo_d;
      ram_wr_n_q <= ram_wr_n_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_fifo  = rd_fifo_q;
  assign ram_wr_n = ram_wr_n_q;
  assign ram_data = ram_data_q;
  assign ram_addr = ram_addr_q;
  assign busy     = busy_q;

endmodule
